// File: rtl/gmii_demux.sv
// gmii_demux: routes each received frame to one of NUM_OUTPUTS byte streams.
// The first byte of every frame selects the output port and is kept as byte 0.
// Each port owns a FIFO with a committed pointer, so a frame only becomes
// visible once its last byte is stored; overflowing frames are rolled back.
// Optional feature macro: GMII_DEMUX_DROP_COUNT_EN adds a saturating
// Drop_count output counting frames dropped for a bad index or overflow.
module gmii_demux #(
    parameter int NUM_OUTPUTS = 2,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [7:0]                  Input_data,
    input  logic                        Input_valid,
    input  logic                        Input_last,
    output logic [NUM_OUTPUTS-1:0][7:0] Output_data,
    output logic [NUM_OUTPUTS-1:0]      Output_valid,
    output logic [NUM_OUTPUTS-1:0]      Output_last,
    input  logic [NUM_OUTPUTS-1:0]      Output_ready
`ifdef GMII_DEMUX_DROP_COUNT_EN
    ,
    output logic [31:0]                 Drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(NUM_OUTPUTS);
    localparam int NP = 1 << IW;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] tgt_q, tgt_d;

    logic [8:0]    mem_q [NUM_OUTPUTS][FIFO_DEPTH];
    logic [PW-1:0] wr_q  [NUM_OUTPUTS];
    logic [PW-1:0] cm_q  [NUM_OUTPUTS];
    logic [PW-1:0] rd_q  [NUM_OUTPUTS];

    logic [NUM_OUTPUTS-1:0] pop;
    logic [NUM_OUTPUTS-1:0] full;
    logic [NP-1:0]          full_pad;

    logic          in_range;
    logic [IW-1:0] idx;
    logic          we;
    logic          commit;
    logic          rollback;
    logic [IW-1:0] wport;

    assign in_range = (Input_data < 8'(NUM_OUTPUTS));
    assign idx      = Input_data[IW-1:0];

    // Read side: committed data is presented directly from the read pointer;
    // a pop this cycle already counts as free space for this cycle's write.
    always_comb begin
        Output_valid = '0;
        Output_last  = '0;
        Output_data  = '0;
        pop          = '0;
        full         = '0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            Output_valid[i] = (rd_q[i] != cm_q[i]);
            {Output_last[i], Output_data[i]} = mem_q[i][rd_q[i][AW-1:0]];
            pop[i]  = Output_valid[i] & Output_ready[i];
            full[i] = ((wr_q[i] - rd_q[i]) == PW'(FIFO_DEPTH)) && !pop[i];
        end
    end

    // Widen the full vector so any decoded index selects a defined bit.
    always_comb begin
        full_pad = '0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            full_pad[i] = full[i];
        end
    end

    // Write FSM: decide per input byte whether to store, commit, roll back or discard.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        we       = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        wport    = tgt_q;
        if (Input_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (in_range && !full_pad[idx]) begin
                        we    = 1'b1;
                        wport = idx;
                        if (Input_last) begin
                            commit = 1'b1;
                        end else begin
                            state_d = WRITE;
                            tgt_d   = idx;
                        end
                    end else if (!Input_last) begin
                        state_d = DROP;
                    end
                end
                WRITE: begin
                    if (full_pad[tgt_q]) begin
                        // Partial frame is abandoned by restoring the write pointer.
                        rollback = 1'b1;
                        state_d  = Input_last ? IDLE : DROP;
                    end else begin
                        we = 1'b1;
                        if (Input_last) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (Input_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and frame target register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Per-port write, committed and read pointers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
                wr_q[i] <= '0;
                cm_q[i] <= '0;
                rd_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
                if (pop[i]) begin
                    rd_q[i] <= rd_q[i] + PW'(1);
                end
                if (wport == IW'(i)) begin
                    if (rollback) begin
                        wr_q[i] <= cm_q[i];
                    end else if (we) begin
                        wr_q[i] <= wr_q[i] + PW'(1);
                        if (commit) begin
                            cm_q[i] <= wr_q[i] + PW'(1);
                        end
                    end
                end
            end
        end
    end

    // FIFO storage: byte plus end-of-frame flag.
    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            if (we && (wport == IW'(i))) begin
                mem_q[i][wr_q[i][AW-1:0]] <= {Input_last, Input_data};
            end
        end
    end

`ifdef GMII_DEMUX_DROP_COUNT_EN
    logic        drop_inc;
    logic [31:0] drop_cnt_q;

    assign drop_inc = Input_valid &&
                      (((state_q == IDLE) && !(in_range && !full_pad[idx])) ||
                       ((state_q == WRITE) && full_pad[tgt_q]));
    assign Drop_count = drop_cnt_q;

    // Saturating count of frames rejected for a bad index or overflow.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gmii_demux.sv
// Bench for gmii_demux: frame-level queue model, directed scenarios, random traffic.
module tb_gmii_demux;

    localparam int N = 2;
    localparam int D = 16;

    logic                Clk = 1'b0;
    logic                Rst_n = 1'b1;
    logic [7:0]          Input_data = '0;
    logic                Input_valid = 1'b0;
    logic                Input_last = 1'b0;
    logic [N-1:0][7:0]   Output_data;
    logic [N-1:0]        Output_valid;
    logic [N-1:0]        Output_last;
    logic [N-1:0]        Output_ready = '1;
`ifdef GMII_DEMUX_DROP_COUNT_EN
    logic [31:0]         Drop_count;
`endif

    gmii_demux #(.NUM_OUTPUTS(N), .FIFO_DEPTH(D)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Input_data(Input_data),
        .Input_valid(Input_valid),
        .Input_last(Input_last),
        .Output_data(Output_data),
        .Output_valid(Output_valid),
        .Output_last(Output_last),
        .Output_ready(Output_ready)
`ifdef GMII_DEMUX_DROP_COUNT_EN
        ,
        .Drop_count(Drop_count)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    bit rand_ready = 1'b0;

    // Model: committed frames per port, frame under construction, drop tally.
    logic [8:0]  cq   [N][$];
    logic [8:0]  pend [$];
    int          mode;      // 0 between frames, 1 collecting, 2 discarding
    int          tgt;
    int unsigned mdrop;
    logic [8:0]  olog [N][$];

    function automatic int occ(int p);
        return cq[p].size() + (((mode == 1) && (tgt == p)) ? pend.size() : 0);
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int p = 0; p < N; p++) cq[p].delete();
            pend.delete();
            mode  = 0;
            tgt   = 0;
            mdrop = 0;
        end else begin
            for (int p = 0; p < N; p++)
                if (Output_ready[p] && cq[p].size() > 0) void'(cq[p].pop_front());
            if (Input_valid) begin
                case (mode)
                    0: begin
                        if (int'(Input_data) < N && occ(int'(Input_data)) < D) begin
                            if (Input_last) begin
                                cq[Input_data].push_back({1'b1, Input_data});
                            end else begin
                                pend.delete();
                                pend.push_back({1'b0, Input_data});
                                tgt  = int'(Input_data);
                                mode = 1;
                            end
                        end else begin
                            mdrop++;
                            if (!Input_last) mode = 2;
                        end
                    end
                    1: begin
                        if (occ(tgt) >= D) begin
                            pend.delete();
                            mdrop++;
                            mode = Input_last ? 0 : 2;
                        end else begin
                            pend.push_back({Input_last, Input_data});
                            if (Input_last) begin
                                foreach (pend[k]) cq[tgt].push_back(pend[k]);
                                pend.delete();
                                mode = 0;
                            end
                        end
                    end
                    default: if (Input_last) mode = 0;
                endcase
            end
        end
    end

    // Compare process: every port checked on every falling edge.
    always @(negedge Clk) begin
        if (started) begin
            for (int p = 0; p < N; p++) begin
                logic expv;
                expv = (cq[p].size() != 0);
                checks++;
                if (Output_valid[p] !== expv) begin
                    errors++;
                    $display("FAIL valid[%0d] t=%0t got %b exp %b", p, $time, Output_valid[p], expv);
                end else if (expv) begin
                    checks++;
                    if ({Output_last[p], Output_data[p]} !== cq[p][0]) begin
                        errors++;
                        $display("FAIL data[%0d] t=%0t got %h exp %h", p, $time,
                                 {Output_last[p], Output_data[p]}, cq[p][0]);
                    end
                end
                if (Output_valid[p] === 1'b1 && Output_ready[p] === 1'b1)
                    olog[p].push_back({Output_last[p], Output_data[p]});
            end
`ifdef GMII_DEMUX_DROP_COUNT_EN
            checks++;
            if (Drop_count !== mdrop) begin
                errors++;
                $display("FAIL drop_count t=%0t got %0d exp %0d", $time, Drop_count, mdrop);
            end
`endif
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic drv(bit v, logic [7:0] d, bit l);
        Input_valid = v;
        Input_data  = v ? d : 8'($urandom);
        Input_last  = v ? l : bit'($urandom);
        if (rand_ready) Output_ready = N'($urandom);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drv(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_logs();
        for (int p = 0; p < N; p++) olog[p].delete();
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        started = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_valid", int'(Output_valid), 0);
        Rst_n = 1'b1;
        idle(2);

        // Three-byte frame to port 1, one-cycle latency.
        clear_logs();
        Output_ready = '1;
        drv(1'b1, 8'h01, 1'b0);
        drv(1'b1, 8'hAA, 1'b0);
        drv(1'b1, 8'hBB, 1'b1);
        chk("t1_latency_valid1", int'(Output_valid[1]), 1);
        chk("t1_latency_data1", int'(Output_data[1]), 8'h01);
        chk("t1_port0_idle", int'(Output_valid[0]), 0);
        idle(6);
        chk("t1_len", olog[1].size(), 3);
        chk("t1_port0_len", olog[0].size(), 0);
        if (olog[1].size() == 3) begin
            chk("t1_b0", int'(olog[1][0]), 9'h001);
            chk("t1_b1", int'(olog[1][1]), 9'h0AA);
            chk("t1_b2", int'(olog[1][2]), 9'h1BB);
        end

        // Invalid destination index.
        clear_logs();
        drv(1'b1, 8'h05, 1'b0);
        drv(1'b1, 8'h11, 1'b1);
        idle(4);
        chk("t2_no_out", olog[0].size() + olog[1].size(), 0);
`ifdef GMII_DEMUX_DROP_COUNT_EN
        chk("t2_drop_count", int'(Drop_count), 1);
`endif

        // Overflow rollback on a stalled port.
        clear_logs();
        Output_ready = 2'b10;
        drv(1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 10; k++) drv(1'b1, 8'(8'h10 + k), k == 10);
        drv(1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 10; k++) drv(1'b1, 8'(8'h20 + k), k == 10);
        idle(3);
        chk("t3_held", int'(Output_valid[0]), 1);
        Output_ready = '1;
        idle(20);
        chk("t3_len", olog[0].size(), 11);
        if (olog[0].size() == 11) begin
            chk("t3_first", int'(olog[0][0]), 9'h000);
            chk("t3_mid", int'(olog[0][5]), 9'h015);
            chk("t3_last", int'(olog[0][10]), 9'h11A);
        end
`ifdef GMII_DEMUX_DROP_COUNT_EN
        chk("t3_drop_count", int'(Drop_count), 2);
`endif

        // Single-byte frame then back-to-back frame, both held in parallel.
        clear_logs();
        Output_ready = '0;
        drv(1'b1, 8'h00, 1'b1);
        drv(1'b1, 8'h01, 1'b0);
        drv(1'b1, 8'h22, 1'b1);
        idle(1);
        chk("t4_both_valid", int'(Output_valid), 3);
        chk("t4_p0", int'({Output_last[0], Output_data[0]}), 9'h100);
        chk("t4_p1", int'({Output_last[1], Output_data[1]}), 9'h001);
        Output_ready = '1;
        idle(5);
        chk("t4_len0", olog[0].size(), 1);
        chk("t4_len1", olog[1].size(), 2);
        if (olog[1].size() == 2) chk("t4_p1_last", int'(olog[1][1]), 9'h122);

        // Reset in the middle of a frame.
        clear_logs();
        drv(1'b1, 8'h00, 1'b0);
        drv(1'b1, 8'h41, 1'b0);
        drv(1'b1, 8'h42, 1'b0);
        Input_valid = 1'b0;
        Rst_n = 1'b0;
        #1;
        chk("t5_reset_valid", int'(Output_valid), 0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        drv(1'b1, 8'h43, 1'b0);
        drv(1'b1, 8'h44, 1'b1);
        drv(1'b1, 8'h01, 1'b0);
        drv(1'b1, 8'h33, 1'b1);
        idle(5);
        chk("t5_port0_len", olog[0].size(), 0);
        chk("t5_port1_len", olog[1].size(), 2);
        if (olog[1].size() == 2) begin
            chk("t5_b0", int'(olog[1][0]), 9'h001);
            chk("t5_b1", int'(olog[1][1]), 9'h133);
        end
`ifdef GMII_DEMUX_DROP_COUNT_EN
        chk("t5_drop_count", int'(Drop_count), 1);
`endif

        // Random traffic with random backpressure; model checks every cycle.
        rand_ready = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = int'($urandom_range(1, 24));
            for (int b = 0; b < len; b++) begin
                logic [7:0] d;
                d = (b == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                while ($urandom_range(0, 7) == 0) idle(1);
                drv(1'b1, d, b == len - 1);
            end
            idle(int'($urandom_range(0, 2)));
        end
        rand_ready = 1'b0;
        Output_ready = '1;
        begin
            int budget;
            budget = 0;
            while ((cq[0].size() != 0 || cq[1].size() != 0) && budget < 200) begin
                idle(1);
                budget++;
            end
            chk("drain_in_budget", int'(budget < 200), 1);
        end
        idle(2);
        chk("drained_valid", int'(Output_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
